// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - BTB geometry and update record shared by the BTB cache and its update queue
package btb_pkg;

    localparam int BTB_IDX_LSB = 2;
    localparam int BTB_IDX_W   = 9;
    localparam int BTB_TAG_W   = 21;
    localparam int BTB_PC_W    = BTB_TAG_W + BTB_IDX_W + BTB_IDX_LSB;

    typedef struct packed {
        logic [BTB_PC_W-1:0] pc;
        logic [BTB_PC_W-1:0] target;
    } btb_upd_t;

endpackage

// File: rtl/btb_update_queue_if.sv
// rtl/btb_update_queue_if.sv - resolved-branch report channel in, BTB write port out
interface btb_update_queue_if #(
    parameter int PC_W = 32
);
    logic            res_valid;
    logic            res_ready;
    logic [PC_W-1:0] res_pc;
    logic [PC_W-1:0] res_target;
    logic            res_taken;
    logic            res_btb_hit;
    logic [PC_W-1:0] res_btb_target;
    logic [PC_W-1:0] write_PC;
    logic [PC_W-1:0] write_data;
    logic            write_bit_ID;

    modport master (
        output res_valid, res_pc, res_target, res_taken, res_btb_hit, res_btb_target,
        input  res_ready, write_PC, write_data, write_bit_ID
    );

    modport slave (
        input  res_valid, res_pc, res_target, res_taken, res_btb_hit, res_btb_target,
        output res_ready, write_PC, write_data, write_bit_ID
    );
endinterface

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - update FIFO with tail-target overwrite and exported entries for the bypass
module btb_upd_fifo #(
    parameter int  DEPTH = 4,
    parameter int  PC_W  = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       push,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [PC_W-1:0]            push_target,
    input  logic                       ovw,
    input  logic [PC_W-1:0]            ovw_target,
    input  logic                       pop,
    output logic [PC_W-1:0]            head_pc,
    output logic [PC_W-1:0]            head_target,
    output logic [PC_W-1:0]            tail_pc,
    output logic [CW-1:0]              count,
    output logic [PW-1:0]              rd_ptr,
    output logic [DEPTH-1:0][PC_W-1:0] ent_pc,
    output logic [DEPTH-1:0][PC_W-1:0] ent_target,
    output logic [DEPTH-1:0]           ent_valid
);

    logic [DEPTH-1:0][PC_W-1:0] pc_q;
    logic [DEPTH-1:0][PC_W-1:0] tgt_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [CW-1:0]              cnt_q;
    logic [PW-1:0]              tail_idx;

    assign tail_idx = wr_ptr_q - PW'(1);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q     <= '0;
            tgt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr_q]  <= push_pc;
                tgt_q[wr_ptr_q] <= push_target;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (ovw) begin
                tgt_q[tail_idx] <= ovw_target;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!push && pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        logic [PW-1:0] off;
        assign off          = PW'(g) - rd_ptr_q;
        assign ent_valid[g] = CW'(off) < cnt_q;
    end

    assign head_pc     = pc_q[rd_ptr_q];
    assign head_target = tgt_q[rd_ptr_q];
    assign tail_pc     = pc_q[tail_idx];
    assign count       = cnt_q;
    assign rd_ptr      = rd_ptr_q;
    assign ent_pc      = pc_q;
    assign ent_target  = tgt_q;

endmodule

// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - filters, coalesces and buffers resolved-branch BTB updates, drains one write per cycle
module btb_update_queue
    import btb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  PC_W  = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    btb_update_queue_if.slave    upd,
    input  logic                 hold,
    input  logic [PC_W-1:0]      query_PC,
    output logic                 pend_hit,
    output logic [PC_W-1:0]      pend_target,
    output logic [CW-1:0]        count,
    output logic [15:0]          filt_cnt
);

    logic [PC_W-1:0]            head_pc;
    logic [PC_W-1:0]            head_target;
    logic [PC_W-1:0]            tail_pc;
    logic [PW-1:0]              rd_ptr;
    logic [DEPTH-1:0][PC_W-1:0] ent_pc;
    logic [DEPTH-1:0][PC_W-1:0] ent_target;
    logic [DEPTH-1:0]           ent_valid;

    logic            acc;
    logic            need;
    logic            pop;
    logic            coal;
    logic            push;
    logic            wb_q;
    logic [PC_W-1:0] wpc_q;
    logic [PC_W-1:0] wdata_q;
    logic [15:0]     filt_q;

    assign upd.res_ready = count < CW'(DEPTH);
    assign acc  = upd.res_valid & upd.res_ready;
    assign need = acc & upd.res_taken
                & ~(upd.res_btb_hit & (upd.res_btb_target == upd.res_target));
    assign pop  = ~hold & (count != '0);
    // The tail is also the head when count is 1; merging into an entry leaving this edge would lose it.
    assign coal = need & (count != '0) & (upd.res_pc == tail_pc)
                & ~(pop & (count == CW'(1)));
    assign push = need & ~coal;

    btb_upd_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .push        (push),
        .push_pc     (upd.res_pc),
        .push_target (upd.res_target),
        .ovw         (coal),
        .ovw_target  (upd.res_target),
        .pop         (pop),
        .head_pc     (head_pc),
        .head_target (head_target),
        .tail_pc     (tail_pc),
        .count       (count),
        .rd_ptr      (rd_ptr),
        .ent_pc      (ent_pc),
        .ent_target  (ent_target),
        .ent_valid   (ent_valid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wb_q    <= 1'b0;
            wpc_q   <= '0;
            wdata_q <= '0;
            filt_q  <= '0;
        end else begin
            wb_q <= pop;
            if (pop) begin
                wpc_q   <= head_pc;
                wdata_q <= head_target;
            end
            if (((acc & ~need) | coal) && (filt_q != 16'hFFFF)) begin
                filt_q <= filt_q + 16'd1;
            end
        end
    end

    assign upd.write_bit_ID = wb_q;
    assign upd.write_PC     = wpc_q;
    assign upd.write_data   = wdata_q;
    assign filt_cnt         = filt_q;

    // Walk oldest to youngest so the youngest match is the one left standing.
    logic [PW-1:0] idx;
    always_comb begin
        pend_hit    = 1'b0;
        pend_target = '0;
        idx         = '0;
        if (wb_q && (((wpc_q ^ query_PC) >> BTB_IDX_LSB) == '0)) begin
            pend_hit    = 1'b1;
            pend_target = wdata_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (ent_valid[idx] && (((ent_pc[idx] ^ query_PC) >> BTB_IDX_LSB) == '0)) begin
                pend_hit    = 1'b1;
                pend_target = ent_target[idx];
            end
        end
    end

endmodule
